// File: rtl/ddr_sched_pkg.sv
// Shared definitions for the DDR read scheduler and its arbiter.
package ddr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } schedState_e;

    localparam int BATCH_LEN_DEFAULT = 224;

    // Pointer width that stays legal when only a single requester exists.
    function automatic int ptrWidth(input int numReq);
        return (numReq > 1) ? $clog2(numReq) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or above the pointer,
// wrapping around to index 0. Purely combinational so it can be shared by
// a read or a write scheduler.
module rr_arbiter
    import ddr_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptrWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   pointer_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic found;

    // First pass covers indices at or above the pointer; second pass wraps to the low indices.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_i[j] && (j >= int'(pointer_i))) begin
                grant_o[j] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_i[j]) begin
                grant_o[j] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_read_scheduler.sv
// DDR read scheduler: arbitrates per-requester read requests, issues one
// fixed-length read command per grant and forwards the returned words to
// the winning requester with a single cycle of latency.
module ddr_read_scheduler
    import ddr_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH_VADDR = 24,
    parameter int WIDTH_ADDR  = 32,
    parameter int WIDTH_DATA  = 18,
    parameter int BATCH_LEN   = BATCH_LEN_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             rdDS_req,
    input  logic [NUM_REQ*WIDTH_VADDR-1:0] rdDS_Vaddr,
    input  logic [NUM_REQ*WIDTH_ADDR-1:0]  cfg_base_addr,
    output logic [NUM_REQ-1:0]             rdDS_granted,
    output logic [WIDTH_DATA-1:0]          rdDS_data18bit,
    output logic [NUM_REQ-1:0]             rdDS_data18bit_vld,
    output logic                           ddr_cmd_valid,
    input  logic                           ddr_cmd_ready,
    output logic [WIDTH_ADDR-1:0]          ddr_cmd_addr,
    output logic [$clog2(BATCH_LEN+1)-1:0] ddr_cmd_len,
    input  logic [WIDTH_DATA-1:0]          ddr_rd_data,
    input  logic                           ddr_rd_data_vld,
    output logic                           busy,
    output logic                           err_unexpected
);

    localparam int PTR_W = ptrWidth(NUM_REQ);
    localparam int LEN_W = $clog2(BATCH_LEN + 1);
    localparam logic [LEN_W-1:0] LAST_BEAT = LEN_W'(BATCH_LEN - 1);

    schedState_e           state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [WIDTH_ADDR-1:0] cmdAddr_q, cmdAddr_d;
    logic [NUM_REQ-1:0]    granted_q, granted_d;
    logic [NUM_REQ-1:0]    owner_q, owner_d;
    logic [LEN_W-1:0]      beatCnt_q, beatCnt_d;
    logic [WIDTH_DATA-1:0] rdData_q, rdData_d;
    logic [NUM_REQ-1:0]    rdVld_q, rdVld_d;
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0]    arbGrant;
    logic [WIDTH_ADDR-1:0] winnerAddr;
    logic [PTR_W-1:0]      nextPtr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arbiter (
        .req_i     (rdDS_req),
        .pointer_i (ptr_q),
        .grant_o   (arbGrant)
    );

    // Resolve the one-hot winner into its physical start address and the pointer just past it.
    always_comb begin
        winnerAddr = '0;
        nextPtr    = ptr_q;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (arbGrant[j]) begin
                winnerAddr = cfg_base_addr[j*WIDTH_ADDR +: WIDTH_ADDR]
                           + WIDTH_ADDR'(rdDS_Vaddr[j*WIDTH_VADDR +: WIDTH_VADDR]);
                nextPtr    = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
            end
        end
    end

    // Next-state logic: grant from IDLE, wait for command acceptance, then count returned beats.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cmdAddr_d = cmdAddr_q;
        granted_d = '0;
        owner_d   = owner_q;
        beatCnt_d = beatCnt_q;
        rdData_d  = rdData_q;
        rdVld_d   = '0;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (ddr_rd_data_vld) begin
                    err_d = 1'b1;
                end
                if (|rdDS_req) begin
                    state_d   = ST_CMD;
                    granted_d = arbGrant;
                    owner_d   = arbGrant;
                    cmdAddr_d = winnerAddr;
                    ptr_d     = nextPtr;
                end
            end
            ST_CMD: begin
                if (ddr_rd_data_vld) begin
                    err_d = 1'b1;
                end
                if (ddr_cmd_ready) begin
                    state_d   = ST_DATA;
                    beatCnt_d = '0;
                end
            end
            ST_DATA: begin
                if (ddr_rd_data_vld) begin
                    rdData_d = ddr_rd_data;
                    rdVld_d  = owner_q;
                    if (beatCnt_q == LAST_BEAT) begin
                        state_d   = ST_IDLE;
                        beatCnt_d = '0;
                    end else begin
                        beatCnt_d = beatCnt_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything so a burst in flight is abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cmdAddr_q <= '0;
            granted_q <= '0;
            owner_q   <= '0;
            beatCnt_q <= '0;
            rdData_q  <= '0;
            rdVld_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cmdAddr_q <= cmdAddr_d;
            granted_q <= granted_d;
            owner_q   <= owner_d;
            beatCnt_q <= beatCnt_d;
            rdData_q  <= rdData_d;
            rdVld_q   <= rdVld_d;
            err_q     <= err_d;
        end
    end

    assign rdDS_granted       = granted_q;
    assign rdDS_data18bit     = rdData_q;
    assign rdDS_data18bit_vld = rdVld_q;
    assign ddr_cmd_valid      = (state_q == ST_CMD);
    assign ddr_cmd_addr       = cmdAddr_q;
    assign ddr_cmd_len        = LEN_W'(BATCH_LEN);
    assign busy               = (state_q != ST_IDLE);
    assign err_unexpected     = err_q;

endmodule

// File: tb/tb_ddr_read_scheduler.sv
// Directed self-checking bench for ddr_read_scheduler.
module tb_ddr_read_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int WIDTH_VADDR = 24;
    localparam int WIDTH_ADDR  = 32;
    localparam int WIDTH_DATA  = 18;
    localparam int BATCH_LEN   = 224;

    logic                           clk = 1'b0;
    logic                           reset;
    logic [NUM_REQ-1:0]             rdDS_req;
    logic [NUM_REQ*WIDTH_VADDR-1:0] rdDS_Vaddr;
    logic [NUM_REQ*WIDTH_ADDR-1:0]  cfg_base_addr;
    logic [NUM_REQ-1:0]             rdDS_granted;
    logic [WIDTH_DATA-1:0]          rdDS_data18bit;
    logic [NUM_REQ-1:0]             rdDS_data18bit_vld;
    logic                           ddr_cmd_valid;
    logic                           ddr_cmd_ready;
    logic [WIDTH_ADDR-1:0]          ddr_cmd_addr;
    logic [7:0]                     ddr_cmd_len;
    logic [WIDTH_DATA-1:0]          ddr_rd_data;
    logic                           ddr_rd_data_vld;
    logic                           busy;
    logic                           err_unexpected;

    int checks   = 0;
    int failures = 0;

    ddr_read_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .WIDTH_VADDR (WIDTH_VADDR),
        .WIDTH_ADDR  (WIDTH_ADDR),
        .WIDTH_DATA  (WIDTH_DATA),
        .BATCH_LEN   (BATCH_LEN)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .rdDS_req           (rdDS_req),
        .rdDS_Vaddr         (rdDS_Vaddr),
        .cfg_base_addr      (cfg_base_addr),
        .rdDS_granted       (rdDS_granted),
        .rdDS_data18bit     (rdDS_data18bit),
        .rdDS_data18bit_vld (rdDS_data18bit_vld),
        .ddr_cmd_valid      (ddr_cmd_valid),
        .ddr_cmd_ready      (ddr_cmd_ready),
        .ddr_cmd_addr       (ddr_cmd_addr),
        .ddr_cmd_len        (ddr_cmd_len),
        .ddr_rd_data        (ddr_rd_data),
        .ddr_rd_data_vld    (ddr_rd_data_vld),
        .busy               (busy),
        .err_unexpected     (err_unexpected)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one edge and settle just after it, where outputs are sampled and inputs changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic cmdReady,
                                 input logic rdVld, input logic [17:0] rdData);
        rdDS_req        = req;
        ddr_cmd_ready   = cmdReady;
        ddr_rd_data_vld = rdVld;
        ddr_rd_data     = rdData;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [17:0] beatVal(input int batchId, input int i);
        return 18'(batchId * 1000 + i + 1);
    endfunction

    // One full batch starting from IDLE with requests already driven.
    task automatic doBatch(input int batchId, input logic [3:0] expGrant,
                           input logic [31:0] expAddr, input logic [3:0] reqAfter,
                           input int stall, input bit gapped);
        tick();
        checkOutput("grant", 64'(rdDS_granted), 64'(expGrant));
        checkOutput("cmdValid", 64'(ddr_cmd_valid), 64'd1);
        checkOutput("cmdAddr", 64'(ddr_cmd_addr), 64'(expAddr));
        checkOutput("busyCmd", 64'(busy), 64'd1);
        rdDS_req = reqAfter;
        for (int s = 0; s < stall; s++) begin
            tick();
            checkOutput("stallGrant", 64'(rdDS_granted), 64'd0);
            checkOutput("stallValid", 64'(ddr_cmd_valid), 64'd1);
            checkOutput("stallAddr", 64'(ddr_cmd_addr), 64'(expAddr));
            checkOutput("stallVld", 64'(rdDS_data18bit_vld), 64'd0);
        end
        ddr_cmd_ready = 1'b1;
        tick();
        ddr_cmd_ready = 1'b0;
        checkOutput("dataEntryValid", 64'(ddr_cmd_valid), 64'd0);
        checkOutput("dataEntryGrant", 64'(rdDS_granted), 64'd0);
        checkOutput("dataEntryBusy", 64'(busy), 64'd1);
        for (int i = 0; i < BATCH_LEN; i++) begin
            ddr_rd_data_vld = 1'b1;
            ddr_rd_data     = beatVal(batchId, i);
            tick();
            ddr_rd_data_vld = 1'b0;
            checkOutput("beatData", 64'(rdDS_data18bit), 64'(beatVal(batchId, i)));
            checkOutput("beatVld", 64'(rdDS_data18bit_vld), 64'(expGrant));
            checkOutput("beatBusy", 64'(busy), (i < BATCH_LEN - 1) ? 64'd1 : 64'd0);
            if (gapped && i < BATCH_LEN - 1) begin
                tick();
                checkOutput("gapVld", 64'(rdDS_data18bit_vld), 64'd0);
            end
        end
    endtask

    // Directed sequence covering reset, arbitration, back-pressure, gaps, stray beats and reset mid-burst.
    initial begin
        reset         = 1'b1;
        rdDS_Vaddr    = {24'hFFFFFF, 24'h000100, 24'h000020, 24'h000010};
        cfg_base_addr = {32'hFFFF_FFF0, 32'h8000_0000, 32'h7000_0000, 32'h6000_0000};
        applyStimulus(4'b0000, 1'b0, 1'b0, 18'h0);
        tick();
        tick();
        checkOutput("rstGrant", 64'(rdDS_granted), 64'd0);
        checkOutput("rstData", 64'(rdDS_data18bit), 64'd0);
        checkOutput("rstVld", 64'(rdDS_data18bit_vld), 64'd0);
        checkOutput("rstCmdValid", 64'(ddr_cmd_valid), 64'd0);
        checkOutput("rstCmdAddr", 64'(ddr_cmd_addr), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstErr", 64'(err_unexpected), 64'd0);
        checkOutput("rstLen", 64'(ddr_cmd_len), 64'd224);
        reset = 1'b0;

        // Single request on requester 2 with ten cycles of command back-pressure.
        rdDS_req = 4'b0100;
        doBatch(1, 4'b0100, 32'h8000_0100, 4'b0000, 10, 1'b0);
        tick();
        checkOutput("singleIdleBusy", 64'(busy), 64'd0);
        checkOutput("singleIdleVld", 64'(rdDS_data18bit_vld), 64'd0);
        checkOutput("singleIdleGrant", 64'(rdDS_granted), 64'd0);
        checkOutput("singleIdleErr", 64'(err_unexpected), 64'd0);

        // Fairness from a freshly reset pointer, all requests held; third batch has gapped data.
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        rdDS_req = 4'b1111;
        doBatch(2, 4'b0001, 32'h6000_0010, 4'b1111, 0, 1'b0);
        doBatch(3, 4'b0010, 32'h7000_0020, 4'b1111, 0, 1'b0);
        doBatch(4, 4'b0100, 32'h8000_0100, 4'b1111, 0, 1'b1);
        doBatch(5, 4'b1000, 32'h00FF_FFEF, 4'b1111, 0, 1'b0);
        doBatch(6, 4'b0001, 32'h6000_0010, 4'b0000, 0, 1'b0);
        tick();
        checkOutput("fairIdleBusy", 64'(busy), 64'd0);

        // Stray beat while idle is dropped and latches the error.
        applyStimulus(4'b0000, 1'b0, 1'b1, 18'h3FFFF);
        tick();
        ddr_rd_data_vld = 1'b0;
        checkOutput("strayVld", 64'(rdDS_data18bit_vld), 64'd0);
        checkOutput("strayData", 64'(rdDS_data18bit), 64'(beatVal(6, BATCH_LEN - 1)));
        checkOutput("strayErr", 64'(err_unexpected), 64'd1);
        checkOutput("strayBusy", 64'(busy), 64'd0);
        tick();
        tick();
        tick();
        checkOutput("strayErrSticky", 64'(err_unexpected), 64'd1);

        // Reset clears the error; then grant requester 2 and interrupt its burst after beat 100.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("errCleared", 64'(err_unexpected), 64'd0);
        rdDS_req = 4'b0100;
        tick();
        checkOutput("midGrant", 64'(rdDS_granted), 64'b0100);
        applyStimulus(4'b0000, 1'b1, 1'b0, 18'h0);
        tick();
        ddr_cmd_ready = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            ddr_rd_data_vld = 1'b1;
            ddr_rd_data     = beatVal(7, i);
            tick();
        end
        checkOutput("midBeat100", 64'(rdDS_data18bit), 64'(beatVal(7, 100)));
        checkOutput("midBusy", 64'(busy), 64'd1);
        reset       = 1'b1;
        ddr_rd_data = beatVal(7, 101);
        tick();
        checkOutput("midRstGrant", 64'(rdDS_granted), 64'd0);
        checkOutput("midRstData", 64'(rdDS_data18bit), 64'd0);
        checkOutput("midRstVld", 64'(rdDS_data18bit_vld), 64'd0);
        checkOutput("midRstCmdValid", 64'(ddr_cmd_valid), 64'd0);
        checkOutput("midRstCmdAddr", 64'(ddr_cmd_addr), 64'd0);
        checkOutput("midRstBusy", 64'(busy), 64'd0);
        checkOutput("midRstErr", 64'(err_unexpected), 64'd0);
        checkOutput("midRstLen", 64'(ddr_cmd_len), 64'd224);
        reset       = 1'b0;
        rdDS_req    = 4'b1111;
        ddr_rd_data = beatVal(7, 102);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 18'h0);
        checkOutput("postRstGrant", 64'(rdDS_granted), 64'b0001);
        checkOutput("postRstAddr", 64'(ddr_cmd_addr), 64'h6000_0010);
        checkOutput("postRstVld", 64'(rdDS_data18bit_vld), 64'd0);
        checkOutput("postRstErr", 64'(err_unexpected), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
